// File: rtl/dijkstra_graph_mem_responder_pkg.sv
// Shared types for the Dijkstra graph memory responder: response codes,
// FSM states and the latency counter width.
package dijkstra_mem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RESP,
    RELEASE
  } state_t;

  // Latencies run 1..8, so the counter only ever holds latency-1 (0..7).
  localparam int LAT_CNT_W = 3;

  // Counter preload for a given latency: the response cycle is reached when
  // the counter hits zero.
  function automatic logic [LAT_CNT_W-1:0] lat_preload(input int lat);
    return LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dijkstra_graph_mem_responder_ram.sv
// Dual-port synchronous word RAM holding the graph. Port A (master) reads and
// writes; port B (host preload) only writes. Read data comes straight from the
// array register with one cycle of latency and reflects the contents before
// any write landing on the same edge.
module graph_word_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int DATA_W      = 16,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic [AW-1:0]     a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [AW-1:0]     b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Port B write first so that a same-word port A write on the same edge wins.
  always_ff @(posedge clock) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
  end

endmodule

// File: rtl/dijkstra_graph_mem_responder.sv
// Fixed-latency memory responder for the Dijkstra engine's master port, with a
// four-phase enable/ready handshake and a host preload port into the same RAM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready to accept; only state with wait_request low
//   RD_WAIT | read accepted, counting down READ_LATENCY
//   WR_WAIT | write accepted (already committed), counting down WRITE_LATENCY
//   RESP    | single ready pulse with data/response
//   RELEASE | waiting for the master to drop both enables
module dijkstra_graph_mem_responder
  import dijkstra_mem_pkg::*;
#(
  parameter int                    DEPTH_WORDS   = 4096,
  parameter int                    MADDR_WIDTH   = 32,
  parameter int                    MDATA_WIDTH   = 16,
  parameter logic [MADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY  = 2,
  parameter int                    WRITE_LATENCY = 1,
  localparam int                   WORD_AW       = $clog2(DEPTH_WORDS)
) (
  input  logic                   mem_clock,
  input  logic                   mem_reset,
  input  logic                   mem_read_enable,
  input  logic                   mem_write_enable,
  input  logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_write_data,
  output logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   mem_read_ready,
  output logic                   mem_write_ready,
  output logic [1:0]             mem_write_response,
  output logic                   wait_request,
  input  logic                   load_enable,
  input  logic [WORD_AW-1:0]     load_index,
  input  logic [MDATA_WIDTH-1:0] load_data,
  output logic                   protocol_error
);

  state_t                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  resp_t                  resp_q;
  logic                   is_read_q;
  logic                   rd_capture_q;
  logic [MDATA_WIDTH-1:0] rd_data_q;
  logic                   perr_q;

  logic [MADDR_WIDTH-1:0] offset;
  logic [MADDR_WIDTH-1:0] word;
  resp_t                  dec_resp;
  logic                   accept_wr;
  logic                   accept_rd;
  logic                   ram_we;
  logic                   load_ok;
  logic [MDATA_WIDTH-1:0] ram_rdata;

  assign offset = mem_addr - BASE_ADDR;
  assign word   = offset >> 1;

  // Address decode; an unmapped address outranks misalignment since there is
  // no word to be misaligned against.
  always_comb begin
    dec_resp = OKAY;
    if ((mem_addr < BASE_ADDR) || (word >= MADDR_WIDTH'(DEPTH_WORDS)))
      dec_resp = DECERR;
    else if (offset[0])
      dec_resp = SLVERR;
  end

  // A write wins over a simultaneous read; reset blocks acceptance entirely.
  assign accept_wr = (state_q == IDLE) && mem_write_enable && !mem_reset;
  assign accept_rd = (state_q == IDLE) && !mem_write_enable && mem_read_enable && !mem_reset;
  assign ram_we    = accept_wr && (dec_resp == OKAY);
  assign load_ok   = load_enable && (32'(load_index) < DEPTH_WORDS);

  graph_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (MDATA_WIDTH)
  ) u_ram (
    .clock   (mem_clock),
    .a_addr  (word[WORD_AW-1:0]),
    .a_we    (ram_we),
    .a_wdata (mem_write_data),
    .a_rdata (ram_rdata),
    .b_addr  (load_index),
    .b_we    (load_ok),
    .b_wdata (load_data)
  );

  // State and latency counter register.
  always_ff @(posedge mem_clock) begin
    if (mem_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_write_enable) begin
          state_d = WR_WAIT;
          cnt_d   = lat_preload(WRITE_LATENCY);
        end else if (mem_read_enable) begin
          state_d = RD_WAIT;
          cnt_d   = lat_preload(READ_LATENCY);
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!mem_read_enable && !mem_write_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response capture, read data holding register and sticky protocol error.
  // RAM data for an accepted read is valid one cycle after acceptance, which is
  // exactly when rd_capture_q is high.
  always_ff @(posedge mem_clock) begin
    if (mem_reset) begin
      resp_q       <= OKAY;
      is_read_q    <= 1'b0;
      rd_capture_q <= 1'b0;
      rd_data_q    <= '0;
      perr_q       <= 1'b0;
    end else begin
      rd_capture_q <= accept_rd;
      if (accept_wr || accept_rd) begin
        resp_q    <= dec_resp;
        is_read_q <= accept_rd;
      end
      if (rd_capture_q)
        rd_data_q <= (resp_q == OKAY) ? ram_rdata : '0;
      if ((state_q == IDLE) && mem_write_enable && mem_read_enable)
        perr_q <= 1'b1;
      if (((state_q == RD_WAIT) && !mem_read_enable) ||
          ((state_q == WR_WAIT) && !mem_write_enable))
        perr_q <= 1'b1;
    end
  end

  assign mem_read_ready     = (state_q == RESP) && is_read_q;
  assign mem_write_ready    = (state_q == RESP) && !is_read_q;
  assign mem_read_data      = mem_read_ready ? rd_data_q : '0;
  assign mem_write_response = (state_q == RESP) ? resp_q : OKAY;
  assign wait_request       = (state_q != IDLE) || mem_reset;
  assign protocol_error     = perr_q;

endmodule

// File: tb/tb_dijkstra_graph_mem_responder.sv
// Scoreboard bench for the graph memory responder: every master transaction
// pushes its expected completion, and a negedge monitor pops and compares each
// ready pulse as it appears.
module tb_dijkstra_graph_mem_responder;

  localparam int DEPTH = 4096;
  localparam int RLAT  = 2;
  localparam int WLAT  = 1;

  logic        mem_clock = 1'b0;
  logic        mem_reset = 1'b1;
  logic        mem_read_enable = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [15:0] mem_write_data = '0;
  logic [15:0] mem_read_data;
  logic        mem_read_ready;
  logic        mem_write_ready;
  logic [1:0]  mem_write_response;
  logic        wait_request;
  logic        load_enable = 1'b0;
  logic [11:0] load_index = '0;
  logic [15:0] load_data = '0;
  logic        protocol_error;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mdl [int];

  dijkstra_graph_mem_responder #(
    .DEPTH_WORDS   (DEPTH),
    .MADDR_WIDTH   (32),
    .MDATA_WIDTH   (16),
    .BASE_ADDR     (32'h0000_0000),
    .READ_LATENCY  (RLAT),
    .WRITE_LATENCY (WLAT)
  ) dut (
    .mem_clock          (mem_clock),
    .mem_reset          (mem_reset),
    .mem_read_enable    (mem_read_enable),
    .mem_write_enable   (mem_write_enable),
    .mem_addr           (mem_addr),
    .mem_write_data     (mem_write_data),
    .mem_read_data      (mem_read_data),
    .mem_read_ready     (mem_read_ready),
    .mem_write_ready    (mem_write_ready),
    .mem_write_response (mem_write_response),
    .wait_request       (wait_request),
    .load_enable        (load_enable),
    .load_index         (load_index),
    .load_data          (load_data),
    .protocol_error     (protocol_error)
  );

  always #5 mem_clock = ~mem_clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge mem_clock) begin
    if (mem_read_ready || mem_write_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_ready", 32'({mem_read_ready, mem_write_ready}), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("ready_kind", 32'({mem_read_ready, mem_write_ready}),
                  32'({e.is_read, !e.is_read}));
        check_val("rdata", 32'(mem_read_data), 32'(e.data));
        check_val("resp", 32'(mem_write_response), 32'(e.resp));
      end
    end
  end

  task automatic host_load(input logic [11:0] idx, input logic [15:0] val);
    @(negedge mem_clock);
    load_enable = 1'b1;
    load_index  = idx;
    load_data   = val;
    mdl[int'(idx)] = val;
    @(negedge mem_clock);
    load_enable = 1'b0;
  endtask

  // One master transaction. The enable is held until the ready pulse plus
  // hold_extra cycles; do_load drives the host port in the acceptance cycle.
  task automatic xfer(input bit wr, input bit both, input logic [31:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp_data,
                      input logic [1:0] exp_resp, input int hold_extra,
                      input bit do_load, input logic [11:0] lidx, input logic [15:0] ldat);
    exp_t e;
    int   n;
    bit   got;
    e.is_read = !wr;
    e.data    = wr ? 16'h0 : exp_data;
    e.resp    = exp_resp;
    sb.push_back(e);
    @(negedge mem_clock);
    mem_addr         = addr;
    mem_write_data   = wdata;
    mem_write_enable = wr;
    mem_read_enable  = !wr || both;
    if (do_load) begin
      load_enable = 1'b1;
      load_index  = lidx;
      load_data   = ldat;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge mem_clock);
      n++;
      load_enable = 1'b0;
      check_val("wait_busy", 32'(wait_request), 32'h1);
      if (mem_read_ready || mem_write_ready) got = 1'b1;
    end
    if (!got) check_val("timeout", 32'h0, 32'h1);
    else      check_val("latency", 32'(n), 32'((wr ? WLAT : RLAT) + 1));
    repeat (hold_extra) @(negedge mem_clock);
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    repeat (2) @(negedge mem_clock);
    check_val("wait_idle", 32'(wait_request), 32'h0);
  endtask

  task automatic mwrite(input logic [31:0] addr, input logic [15:0] d,
                        input logic [1:0] resp, input int hold);
    xfer(1'b1, 1'b0, addr, d, 16'h0, resp, hold, 1'b0, 12'h0, 16'h0);
  endtask

  task automatic mread(input logic [31:0] addr, input logic [15:0] d, input logic [1:0] resp);
    xfer(1'b0, 1'b0, addr, 16'h0, d, resp, 0, 1'b0, 12'h0, 16'h0);
  endtask

  initial begin
    repeat (3) @(negedge mem_clock);
    check_val("rst_wait", 32'(wait_request), 32'h1);
    check_val("rst_ready", 32'({mem_read_ready, mem_write_ready}), 32'h0);
    check_val("rst_data", 32'(mem_read_data), 32'h0);
    check_val("rst_resp", 32'(mem_write_response), 32'h0);
    check_val("rst_perr", 32'(protocol_error), 32'h0);
    mem_reset = 1'b0;
    @(negedge mem_clock);
    check_val("idle_wait", 32'(wait_request), 32'h0);

    // Preload then read back through the master port.
    host_load(12'd5, 16'h00A7);
    mread(32'h0A, 16'h00A7, 2'b00);

    // Write with enable held past the ready pulse, then read it back.
    mwrite(32'h10, 16'h1234, 2'b00, 3);
    mread(32'h10, 16'h1234, 2'b00);

    // Decode errors.
    mread(32'h0B, 16'h0000, 2'b10);
    mread(32'(2 * DEPTH), 16'h0000, 2'b11);
    host_load(12'd0, 16'h5A5A);
    mwrite(32'(2 * DEPTH), 16'hDEAD, 2'b11, 0);
    mread(32'h0, 16'h5A5A, 2'b00);
    check_val("perr_clean", 32'(protocol_error), 32'h0);

    // Mixed traffic against the bench model.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d;
      d = 16'($urandom_range(0, 16'hFFFF));
      mdl[40 + 3 * i] = d;
      mwrite(32'(2 * (40 + 3 * i)), d, 2'b00, i % 2);
    end
    for (int i = 5; i >= 0; i--)
      mread(32'(2 * (40 + 3 * i)), mdl[40 + 3 * i], 2'b00);

    // Load and master write to word 7 on the same edge: master wins.
    xfer(1'b1, 1'b0, 32'h0E, 16'h0001, 16'h0, 2'b00, 0, 1'b1, 12'd7, 16'hFFFF);
    mread(32'h0E, 16'h0001, 2'b00);

    // Both enables in IDLE: write only, sticky protocol error.
    xfer(1'b1, 1'b1, 32'h20, 16'hBEEF, 16'h0, 2'b00, 0, 1'b0, 12'h0, 16'h0);
    check_val("perr_set", 32'(protocol_error), 32'h1);
    mread(32'h20, 16'hBEEF, 2'b00);
    check_val("perr_sticky", 32'(protocol_error), 32'h1);

    // Reset during RD_WAIT aborts the read; no expectation is pushed for it.
    @(negedge mem_clock);
    mem_addr        = 32'h0A;
    mem_read_enable = 1'b1;
    @(negedge mem_clock);
    check_val("abort_busy", 32'(wait_request), 32'h1);
    mem_reset = 1'b1;
    @(negedge mem_clock);
    check_val("abort_ready", 32'({mem_read_ready, mem_write_ready}), 32'h0);
    check_val("abort_data", 32'(mem_read_data), 32'h0);
    check_val("abort_resp", 32'(mem_write_response), 32'h0);
    check_val("abort_perr", 32'(protocol_error), 32'h0);
    check_val("abort_wait", 32'(wait_request), 32'h1);
    mem_reset       = 1'b0;
    mem_read_enable = 1'b0;
    repeat (4) @(negedge mem_clock);
    check_val("abort_idle", 32'(wait_request), 32'h0);
    mread(32'h0A, 16'h00A7, 2'b00);
    mread(32'h0E, 16'h0001, 2'b00);

    repeat (3) @(negedge mem_clock);
    check_val("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dijkstra_graph_mem_responder.md
Name: dijkstra_graph_mem_responder

Overview:
- On-chip memory responder serving the Dijkstra engine's memory master port: word reads and writes of graph/adjacency data with a fixed-latency, four-phase enable/ready handshake.
- Sits between the algorithm block's memory master signals and a dual-port word RAM.
- A second, host-side load port lets the CPU or testbench preload the graph before a run.
- Replaces the constant-zero wait_request tie-off with a real busy indication.

Parameters:
- DEPTH_WORDS, 4096, number of MDATA_WIDTH-bit words stored.
- MADDR_WIDTH, 32, byte-address width of the master port.
- MDATA_WIDTH, 16, data word width.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- READ_LATENCY, 2, cycles from read acceptance to mem_read_ready. Legal range 1..8.
- WRITE_LATENCY, 1, cycles from write acceptance to mem_write_ready. Legal range 1..8.

Ports:
- mem_clock  in  1  single clock for the whole block.
- mem_reset  in  1  synchronous, active-high reset.
- mem_read_enable  in  1  master read request; held until mem_read_ready.
- mem_write_enable  in  1  master write request; held until mem_write_ready.
- mem_addr  in  MADDR_WIDTH  byte address; stable while an enable is high.
- mem_write_data  in  MDATA_WIDTH  write data; stable while mem_write_enable is high.
- mem_read_data  out  MDATA_WIDTH  read data; valid only in the mem_read_ready cycle.
- mem_read_ready  out  1  one-cycle read completion pulse.
- mem_write_ready  out  1  one-cycle write completion pulse.
- mem_write_response  out  2  00 OKAY, 10 SLVERR, 11 DECERR; valid with either ready pulse.
- wait_request  out  1  high when a new request cannot be accepted.
- load_enable  in  1  host preload write strobe.
- load_index  in  $clog2(DEPTH_WORDS)  host word index.
- load_data  in  MDATA_WIDTH  host word data.
- protocol_error  out  1  sticky flag; cleared only by mem_reset.

Behaviour:
- Reset (synchronous): state IDLE, latency counter 0. All outputs 0 except wait_request, which is 1 while mem_reset is high. RAM contents are preserved, not cleared.
- Reset mid-transaction aborts the transaction; no ready pulse is ever issued for it.
- Address decode:
  - offset = mem_addr - BASE_ADDR (MADDR_WIDTH-bit wrap-around subtraction); word = offset >> 1.
  - offset[0]=1 gives SLVERR.
  - mem_addr < BASE_ADDR, or word >= DEPTH_WORDS, gives DECERR.
  - On any error: no RAM write; read data returned as 0.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP, RELEASE.
- IDLE:
  - mem_write_enable high: latch address and data, go to WR_WAIT, counter = WRITE_LATENCY-1.
  - Else if mem_read_enable high: latch address, go to RD_WAIT, counter = READ_LATENCY-1.
  - Both enables high: serviced as a write only, and protocol_error is set. No read_ready is issued for that read.
- RD_WAIT / WR_WAIT:
  - Counter decrements each cycle; at 0, go to RESP.
  - Decode result and the RAM write commit on the acceptance cycle. The RAM read is issued on the acceptance cycle (synchronous RAM, 1-cycle read).
  - Read data is held in a register until RESP.
- RESP:
  - Exactly one ready pulse with data/response.
  - Request accepted at edge T, so ready is high in cycle T+LATENCY.
  - Next state RELEASE.
- RELEASE:
  - Stay until both enables are low, then IDLE.
  - Prevents a held enable from being re-accepted; this is a four-phase handshake.
- wait_request is high in every state except IDLE.
- An enable that drops before its ready pulse: the transaction still completes and the pulse is still issued; protocol_error is set.
- Load port:
  - Writes RAM port B on any cycle, in any state, with no handshake.
  - load_index >= DEPTH_WORDS is ignored.
  - Same-cycle, same-word collision with a master write: master write wins.
  - Same-word collision with a master read: the read returns old data.
- Throughput: at most one transaction per READ/WRITE_LATENCY+2 cycles.

Decomposition:
- Package dijkstra_mem_pkg:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - State enum.
  - Latency-counter width constant of 3 bits.
- Sub-module graph_word_ram: true dual-port synchronous RAM with DEPTH_WORDS x MDATA_WIDTH and no output register.
  - Port A: read/write, used by the master path.
  - Port B: write-only, used by the load port.
  - Port A write priority on collisions.

Test Plan:
- Load word 5 = 16'h00A7 via load port; with READ_LATENCY=2, master reads addr 32'h0A (accepted edge T) -> mem_read_ready only in T+2 with data 16'h00A7 and response 00; wait_request high T+1..release.
- Master writes 16'h1234 to addr 32'h10, keeps enable high 3 extra cycles, then reads addr 32'h10 -> exactly one write_ready, response 00; read returns 16'h1234.
- Read addr 32'h0B (odd) -> response 10, data 0. Read addr 2*DEPTH_WORDS -> response 11, data 0. Write to out-of-range address -> RAM unchanged (verified by load+readback).
- Both enables high in IDLE -> single write_ready, no read_ready, protocol_error=1 until mem_reset.
- mem_reset asserted during RD_WAIT -> no ready pulse, all outputs 0 next cycle, RAM contents intact.
- Same-cycle load_index=7 (16'hFFFF) and master write word 7 (16'h0001) -> word 7 reads 16'h0001.
